skewed_desync: RTL
==================

// Module: skewed_desync
// PURPOSE
//  Two-channel stochastic bitstream desynchronizer. This is the counterpart of the skewed synchronizer:
//  it pushes the 1s of the two streams apart so that out[1] & out[0] is minimised (negative correlation).
//  It preserves each stream's 1-count, up to counter capacity and the bits still pending at any moment.
//  Sits in front of SC subtractors, OR-adders and max/min units that need anti-correlated operands.
// PARAMETERS
//  DEPTH   4   width of each per-channel save counter; capacity 2^DEPTH-1 deferred 1s per channel
// PORTS
//  clk       in   1      clock
//  rst_n     in   1      reset, asynchronous, active-low
//  en        in   1      1: desync active; 0: bypass (out = in), counters hold
//  in        in   2      input bitstreams; bit 1 and bit 0 are the two operands
//  out       out  2      desynchronized bitstreams; combinational from in + state (zero latency)
//  pending   out  1      1 when any save counter is nonzero
// BEHAVIOUR
//  State
//   - cnt1, cnt0: DEPTH-bit saturating save counters.
//   - pri: 1-bit priority flag; value = index of the channel that emits on the next 11 input.
//   - Reset: cnt1 = cnt0 = 0, pri = 1.
//   - During reset, out = combinational function of in with zero counters; pending = 0.
//  Per cycle with en=1; "sat" means cnt == 2^DEPTH-1; tgt = ~pri is the channel to defer.
//   - in=11:
//     - If cnt[tgt] is not sat: out[pri]=1, out[tgt]=0, cnt[tgt]++, pri toggles.
//     - Else if cnt[pri] is not sat: out[tgt]=1, out[pri]=0, cnt[pri]++, pri holds.
//     - Else: out=11; no count change; this is the only overlap case.
//   - in=00:
//     - If pending: release one saved bit from the channel with the larger count (tie -> channel pri).
//     - That channel's out bit = 1 and its cnt-- ; the other out bit = 0.
//     - Otherwise out=00.
//   - in=10 or 01: out=in. Counters and pri hold; a release here would create overlap, so none occurs.
//   - At most one counter changes per cycle, by exactly 1; never wraps (sat/zero checks above).
//  en=0: out=in, pending reflects held counts, no state change. Toggling en loses no bits.
//  Conservation invariant, per channel: (#1s into in[i]) = (#1s out of out[i]) + cnt_i.
//  Async reset mid-stream discards pending bits; this is intended and is the user's responsibility.
// CONFIGURATION
//  SKEWED_DESYNC_ALT_EN defined:
//   - Alternating priority as above.
//   - Deferral and release balanced between channels.
//  SKEWED_DESYNC_ALT_EN undefined (skewed mode):
//   - pri is fixed at 1 (no flag register); only cnt0 exists and cnt1 is tied to 0.
//   - in=11: out=10 and cnt0++ if cnt0 is not sat, else out=11.
//   - in=00: out=01 and cnt0-- if cnt0 != 0.
//   - Channel 1 always passes unmodified; pending = |cnt0.
// TESTING (DEPTH=4)
//  1. Reset release, in=11 for 3 cycles, ALT_EN:
//     -> out = 10, 01, 10; cnt0=2, cnt1=1; pending=1; no cycle with out=11.
//  2. After test 1, in=00 for 4 cycles:
//     -> out = 01, 10, 01, 00 (larger count first, then tie->pri); pending falls after cycle 3.
//  3. in=11 for 31 cycles, ALT_EN:
//     -> the first 30 outputs are single-hot; cnt0=cnt1=15; cycle 31 out=11; counters hold at 15.
//  4. Skewed mode (macro off), in=11 x16 then 00 x16:
//     -> out=10 x15, 11 x1, then 01 x15, 00 x1; out[1] equals in[1] every cycle.
//  5. Random Bernoulli streams p1=0.75, p0=0.5, 4096 cycles, then 00 until pending=0, both modes:
//     -> exact 1-count per channel preserved; overlap count <= the reference (un-desynced) overlap.
//  6. Build cnt0=3, then en=0 with in=11,00 -> out=in, counts frozen; en=1 with in=00 x3 -> out=01 x3.
//  7. Build cnt0=3, cnt1=2, then assert rst_n=0 mid-cycle:
//     -> counters clear immediately (asynchronous), pending=0, pri=1.

Source files
------------

// File: rtl/skewed_desync.sv
// ---------------------------------------------------------------------------
// skewed_desync
//   Two-channel stochastic bitstream desynchronizer. It pushes the 1s of the
//   two input streams apart so that out[1] & out[0] is minimised. When both
//   inputs are 1, one of the 1s is saved in a per-channel counter. The saved
//   1 is released later, on a cycle where both inputs are 0. The 1-count of
//   each stream is preserved, up to counter capacity and the bits still
//   pending.
//
// Configuration macro: SKEWED_DESYNC_ALT_EN
//   defined   : alternating priority. Both channels have a save counter, and
//               deferral and release are balanced between the channels.
//   undefined : skewed mode. Only channel 0 has a save counter, and
//               channel 1 always passes through unmodified.
//
// Parameters
//   DEPTH    width of each save counter. Capacity is 2^DEPTH-1 deferred 1s.
//
// Ports
//   clk      in   1   clock
//   rst_n    in   1   asynchronous active-low reset
//   en       in   1   1: desync active; 0: bypass (out = in), state holds
//   in       in   2   input bitstreams (two operands)
//   out      out  2   desynchronized bitstreams, combinational (zero latency)
//   pending  out  1   any save counter nonzero
// ---------------------------------------------------------------------------
module skewed_desync #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] in,
    output logic [1:0] out,
    output logic       pending
);

    localparam logic [DEPTH-1:0] CNT_MAX = '1;
    localparam logic [DEPTH-1:0] CNT_ONE = DEPTH'(1);

`ifdef SKEWED_DESYNC_ALT_EN

    logic [1:0][DEPTH-1:0] cnt, cnt_nxt;
    logic                  pri, pri_nxt;  // channel that emits on the next 11
    logic                  tgt;           // channel to defer on the next 11
    logic                  src;           // channel released on a 00
    logic [1:0]            sat;

    assign tgt     = ~pri;
    assign sat     = {cnt[1] == CNT_MAX, cnt[0] == CNT_MAX};
    assign pending = |cnt;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
        out     = in;
        cnt_nxt = cnt;
        pri_nxt = pri;
        src     = pri;
        if (en) begin
            case (in)
                2'b11: begin
                    if (!sat[tgt]) begin
                        out          = 2'b00;
                        out[pri]     = 1'b1;
                        cnt_nxt[tgt] = cnt[tgt] + CNT_ONE;
                        pri_nxt      = tgt;
                    end else if (!sat[pri]) begin
                        // The deferral channel is full, so the other channel stores
                        // the bit instead. Priority stays where it is.
                        out          = 2'b00;
                        out[tgt]     = 1'b1;
                        cnt_nxt[pri] = cnt[pri] + CNT_ONE;
                    end
                    // Both counters are full: 11 passes through. This is the only overlap.
                end
                2'b00: begin
                    if (pending) begin
                        // Drain the fuller channel first. On a tie, release from pri.
                        if (cnt[1] > cnt[0]) begin
                            src = 1'b1;
                        end else if (cnt[0] > cnt[1]) begin
                            src = 1'b0;
                        end
                        out          = 2'b00;
                        out[src]     = 1'b1;
                        cnt_nxt[src] = cnt[src] - CNT_ONE;
                        // Toggling pri on a release spreads later ties across both channels.
                        pri_nxt      = ~pri;
                    end
                end
                default: ;  // 10 / 01: a release here would create overlap
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            pri <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            cnt <= cnt_nxt;
            pri <= pri_nxt;
        end
    end

`else

    // Skewed mode: channel 1 always has priority, and cnt1 is implicitly zero.
    logic [DEPTH-1:0] cnt0, cnt0_nxt;

    assign pending = |cnt0;

    always_comb begin
        out      = in;
        cnt0_nxt = cnt0;
        if (en) begin
            case (in)
                2'b11: begin
                    if (cnt0 != CNT_MAX) begin
                        out      = 2'b10;
                        cnt0_nxt = cnt0 + CNT_ONE;
                    end
                end
                2'b00: begin
                    if (cnt0 != '0) begin
                        out      = 2'b01;
                        cnt0_nxt = cnt0 - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
        end else begin
            cnt0 <= cnt0_nxt;
        end
    end

`endif

endmodule
